vector_frame_writer: RTL and testbench

Producer-side counterpart to the vector display's ROM/RAM reader. Accepts a stream of beam points (x, y, draw, last) over a valid/ready handshake, packs each into the display's 18-bit vector word, and writes it into the back bank of a double-buffered vector RAM. A bank swap is held until the display reports the end of its current frame. The display therefore always scans a complete, end-terminated list while the next one is built.

---
 rtl/vector_frame_writer.sv | 125 ++++++++++++
 tb/tb_vector_frame_writer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_frame_writer.sv
`default_nettype none
// ============================================================================
// vector_frame_writer
// Packs beam points into vector words and fills the back bank of a
// double-buffered vector RAM; banks swap only at the display's frame end.
// Revision: 1.0
// ============================================================================
module vector_frame_writer #(
    parameter int ADDRESSWIDTH = 4,
    parameter int DATAWIDTH    = 18,
    parameter int OUT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pt_valid,
    output logic                    pt_ready,
    input  logic [OUT_WIDTH-1:0]    pt_x,
    input  logic [OUT_WIDTH-1:0]    pt_y,
    input  logic                    pt_draw,
    input  logic                    pt_last,
    input  logic                    disp_frame_done,
    output logic                    wr_en,
    output logic                    wr_bank,
    output logic [ADDRESSWIDTH-1:0] wr_addr,
    output logic [DATAWIDTH-1:0]    wr_data,
    output logic                    rd_bank,
    output logic                    overflow
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_DROP = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDRESSWIDTH-1:0] r_cnt;
    logic                    r_rd_bank;
    logic                    r_overflow;
    logic                    r_wr_en;
    logic [ADDRESSWIDTH-1:0] r_wr_addr;
    logic [DATAWIDTH-1:0]    r_wr_data;
    logic                    w_accept;
    logic                    w_cnt_max;
    logic [DATAWIDTH-1:0]    w_word;

    assign pt_ready  = ~rst & ((r_state == S_FILL) | (r_state == S_DROP));
    assign w_accept  = pt_valid & pt_ready;
    assign w_cnt_max = (r_cnt == {ADDRESSWIDTH{1'b1}});
    // The word at the top address is always end-flagged so the display never runs off the bank.
    assign w_word    = {pt_y, pt_x, pt_draw, pt_last | w_cnt_max};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    if (pt_last) begin
                        w_next_state = S_WAIT;
                    end else if (w_cnt_max) begin
                        w_next_state = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (w_accept && pt_last) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (disp_frame_done) begin
                    w_next_state = S_FILL;
                end
            end
            default: w_next_state = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rd_bank  <= 1'b0;
            r_overflow <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if ((r_state == S_FILL) && w_accept) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_cnt;
                r_wr_data <= w_word;
                if (!pt_last) begin
                    if (w_cnt_max) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
            if ((r_state == S_WAIT) && disp_frame_done) begin
                r_rd_bank <= ~r_rd_bank;
                r_cnt     <= '0;
            end
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign rd_bank  = r_rd_bank;
    assign wr_bank  = ~r_rd_bank;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vector_frame_writer.sv
`default_nettype none
// ============================================================================
// tb_vector_frame_writer
// Scoreboard bench: expected RAM writes are queued as points are offered.
// Revision: 1.0
// ============================================================================
module tb_vector_frame_writer;

    localparam int AW = 4;
    localparam int DW = 18;
    localparam int OW = 8;

    typedef struct {
        logic          bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pt_valid = 1'b0;
    logic          pt_ready;
    logic [OW-1:0] pt_x = '0;
    logic [OW-1:0] pt_y = '0;
    logic          pt_draw = 1'b0;
    logic          pt_last = 1'b0;
    logic          disp_frame_done = 1'b0;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_bank;
    logic          overflow;

    exp_t          q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    // Reference model of the writer's bookkeeping
    logic [AW-1:0] m_cnt  = '0;
    logic          m_rd   = 1'b0;
    logic          m_drop = 1'b0;
    logic          m_wait = 1'b0;

    vector_frame_writer #(
        .ADDRESSWIDTH(AW),
        .DATAWIDTH   (DW),
        .OUT_WIDTH   (OW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pt_valid       (pt_valid),
        .pt_ready       (pt_ready),
        .pt_x           (pt_x),
        .pt_y           (pt_y),
        .pt_draw        (pt_draw),
        .pt_last        (pt_last),
        .disp_frame_done(disp_frame_done),
        .wr_en          (wr_en),
        .wr_bank        (wr_bank),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_bank        (rd_bank),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            exp_t e;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got bank=%0b addr=%0d data=%h, expected no write",
                         wr_bank, wr_addr, wr_data);
            end else begin
                e = q.pop_front();
                if ({wr_bank, wr_addr, wr_data} !== {e.bank, e.addr, e.data}) begin
                    n_fail++;
                    $display("FAIL write_word: got bank=%0b addr=%0d data=%h, expected bank=%0b addr=%0d data=%h",
                             wr_bank, wr_addr, wr_data, e.bank, e.addr, e.data);
                end
            end
        end
    end

    task automatic send_point(input logic [OW-1:0] x, input logic [OW-1:0] y,
                              input logic d, input logic l, input logic done);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        pt_x = x; pt_y = y; pt_draw = d; pt_last = l;
        pt_valid = 1'b1;
        disp_frame_done = done;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pt_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: got pt_ready=%0b, expected 1 within 50 cycles", pt_ready);
        end else begin
            if (!m_drop) begin
                e.bank = ~m_rd;
                e.addr = m_cnt;
                e.data = {y, x, d, l | (m_cnt == {AW{1'b1}})};
                q.push_back(e);
            end
            if (l) begin
                m_wait = 1'b1;
            end else if (!m_drop) begin
                if (m_cnt == {AW{1'b1}}) m_drop = 1'b1;
                else                     m_cnt  = m_cnt + 1'b1;
            end
        end
        @(posedge clk);
        #1;
        pt_valid = 1'b0;
        disp_frame_done = 1'b0;
    endtask

    task automatic pulse_done();
        disp_frame_done = 1'b1;
        @(posedge clk);
        #1;
        disp_frame_done = 1'b0;
        if (m_wait) begin
            m_rd   = ~m_rd;
            m_cnt  = '0;
            m_wait = 1'b0;
            m_drop = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d writes outstanding, expected 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pt_valid = 1'b1;
        pt_x = 8'd7; pt_y = 8'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({pt_ready, wr_en, rd_bank} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_hold: got ready=%0b wr_en=%0b rd_bank=%0b, expected 0 0 0",
                         pt_ready, wr_en, rd_bank);
            end
        end
        rst = 1'b0;
        pt_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (pt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %0b, expected 1", pt_ready);
        end
        n_checks++;
        if ({wr_en, wr_bank, wr_addr, wr_data, overflow} !== {1'b0, 1'b1, {AW{1'b0}}, {DW{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got wr_en=%0b wr_bank=%0b addr=%0d data=%h ovf=%0b, expected 0 1 0 0 0",
                     wr_en, wr_bank, wr_addr, wr_data, overflow);
        end
    endtask

    task automatic test_frame();
        send_point(8'd10, 8'd20, 1'b1, 1'b0, 1'b0);
        send_point(8'd30, 8'd40, 1'b0, 1'b0, 1'b0);
        send_point(8'd50, 8'd60, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (pt_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_wait_ready: got %0b, expected 0", pt_ready);
        end
    endtask

    task automatic test_swap();
        // Pulse arrives while the final write of the frame is still on the bus.
        pulse_done();
        n_checks++;
        if ({rd_bank, wr_bank, pt_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL swap: got rd_bank=%0b wr_bank=%0b ready=%0b, expected 1 0 1",
                     rd_bank, wr_bank, pt_ready);
        end
        send_point(8'd1, 8'd2, 1'b1, 1'b1, 1'b0);
        drain();
        pulse_done();
        n_checks++;
        if (rd_bank !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_back: got rd_bank=%0b, expected 0", rd_bank);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) begin
            send_point(OW'(i * 3), OW'(i * 5), i[0], (i == 19), 1'b0);
            if (i == 14 || i == 15) begin
                n_checks++;
                if (overflow !== (i == 15)) begin
                    n_fail++;
                    $display("FAIL overflow_edge: point %0d got overflow=%0b, expected %0b",
                             i + 1, overflow, (i == 15));
                end
            end
        end
        drain();
        n_checks++;
        if ({pt_ready, overflow} !== 2'b01) begin
            n_fail++;
            $display("FAIL overflow_wait: got ready=%0b overflow=%0b, expected 0 1", pt_ready, overflow);
        end
        pulse_done();
        n_checks++;
        if ({rd_bank, overflow, pt_ready} !== 3'b111) begin
            n_fail++;
            $display("FAIL overflow_sticky: got rd_bank=%0b overflow=%0b ready=%0b, expected 1 1 1",
                     rd_bank, overflow, pt_ready);
        end
    endtask

    task automatic test_ignored_done();
        logic rb;
        rb = rd_bank;
        send_point(8'd11, 8'd12, 1'b1, 1'b0, 1'b1);
        send_point(8'd13, 8'd14, 1'b0, 1'b0, 1'b0);
        pulse_done();
        n_checks++;
        if (rd_bank !== rb) begin
            n_fail++;
            $display("FAIL done_in_fill: got rd_bank=%0b, expected %0b", rd_bank, rb);
        end
        // Pulse coincides with the accept that enters the wait state.
        send_point(8'd15, 8'd16, 1'b1, 1'b1, 1'b1);
        pt_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({pt_ready, rd_bank} !== {1'b0, rb}) begin
                n_fail++;
                $display("FAIL wait_hold: cycle %0d got ready=%0b rd_bank=%0b, expected 0 %0b",
                         i, pt_ready, rd_bank, rb);
            end
        end
        pt_valid = 1'b0;
        @(posedge clk);
        #1;
        drain();
        pulse_done();
        n_checks++;
        if ({rd_bank, pt_ready} !== {~rb, 1'b1}) begin
            n_fail++;
            $display("FAIL done_in_wait: got rd_bank=%0b ready=%0b, expected %0b 1", rd_bank, pt_ready, ~rb);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 5; i++) begin
            send_point(OW'(100 + i), OW'(200 - i), 1'b1, 1'b0, 1'b0);
        end
        drain();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({pt_ready, wr_en, rd_bank, overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid: got ready=%0b wr_en=%0b rd_bank=%0b overflow=%0b, expected 0 0 0 0",
                     pt_ready, wr_en, rd_bank, overflow);
        end
        rst = 1'b0;
        m_cnt = '0; m_rd = 1'b0; m_drop = 1'b0; m_wait = 1'b0;
        @(posedge clk);
        #1;
        send_point(8'd77, 8'd88, 1'b0, 1'b1, 1'b0);
        drain();
        pulse_done();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_swap();
        test_overflow();
        test_ignored_done();
        test_reset_mid_frame();
        repeat (3) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: got %0d pending writes, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
